// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the execute stage and a 256x16 word-addressed data
// memory. Takes one byte or word load/store per request handshake, translates
// byte addresses to word indices, does read-modify-write for byte stores and
// lane extraction plus sign/zero extension for byte loads. Misaligned or
// out-of-range requests are answered with a fault code and never reach dmem.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The request side is only ready while
// idle. The response side holds resp_valid and its payload unchanged until
// resp_ready is seen high at a rising edge.
module lsu_dmem_ctrl #(
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic [15:0] dm_addr,
    output logic [15:0] dm_wdata,
    output logic        dm_write,
    output logic        dm_read,
    input  logic [15:0] dm_rdata,
    output logic [2:0]  dbg_state
);

    localparam int          IDX_W      = $clog2(DMEM_DEPTH);
    localparam logic [16:0] ADDR_LIMIT = 17'(2 * DMEM_DEPTH);

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_RMW_RD,
        S_RMW_WAIT,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_size;
    logic        r_signed;
    logic        r_lane;
    logic [7:0]  r_wbyte;
    logic [15:0] r_dm_addr;
    logic [15:0] r_dm_wdata;
    logic        r_dm_write;
    logic        r_dm_read;
    logic        r_resp_valid;
    logic [15:0] r_resp_rdata;
    logic [1:0]  r_resp_fault;

    logic             w_accept;
    logic             w_range_err;
    logic             w_align_err;
    logic [1:0]       w_fault;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_lane_byte;
    logic [15:0]      w_load_fmt;
    logic [15:0]      w_merged;

    assign req_ready  = (r_state == S_IDLE) & ~rst;
    assign w_accept   = req_valid & req_ready;

    // Range violations take priority over misalignment.
    assign w_range_err = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign w_align_err = req_size & req_addr[0];
    assign w_fault     = w_range_err ? FLT_RANGE : (w_align_err ? FLT_ALIGN : FLT_OK);
    assign w_idx       = req_addr[IDX_W:1];

    // Little-endian lane select: byte address bit 0 picks the high byte.
    assign w_lane_byte = r_lane ? dm_rdata[15:8] : dm_rdata[7:0];
    assign w_load_fmt  = r_size ? dm_rdata
                                : {{8{r_signed & w_lane_byte[7]}}, w_lane_byte};
    assign w_merged    = r_lane ? {r_wbyte, dm_rdata[7:0]}
                                : {dm_rdata[15:8], r_wbyte};

    assign dm_addr    = r_dm_addr;
    assign dm_wdata   = r_dm_wdata;
    assign dm_write   = r_dm_write;
    assign dm_read    = r_dm_read;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;
    assign dbg_state  = r_state;

    // Request sequencer: latches the request, drives dmem strobes one state at
    // a time and holds the response until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_size       <= 1'b0;
            r_signed     <= 1'b0;
            r_lane       <= 1'b0;
            r_wbyte      <= 8'd0;
            r_dm_addr    <= 16'd0;
            r_dm_wdata   <= 16'd0;
            r_dm_write   <= 1'b0;
            r_dm_read    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 16'd0;
            r_resp_fault <= FLT_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_lane   <= req_addr[0];
                        r_wbyte  <= req_wdata[7:0];
                        if (w_fault != FLT_OK) begin
                            r_resp_fault <= w_fault;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_dm_addr <= 16'(w_idx);
                            if (req_write && req_size) begin
                                r_dm_write <= 1'b1;
                                r_dm_wdata <= req_wdata;
                                r_state    <= S_WR;
                            end else if (req_write) begin
                                r_dm_read <= 1'b1;
                                r_state   <= S_RMW_RD;
                            end else begin
                                r_dm_read <= 1'b1;
                                r_state   <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    r_dm_read <= 1'b0;
                    r_state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_resp_rdata <= w_load_fmt;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_WR: begin
                    r_dm_write   <= 1'b0;
                    r_dm_wdata   <= 16'd0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RMW_RD: begin
                    r_dm_read <= 1'b0;
                    r_state   <= S_RMW_WAIT;
                end
                S_RMW_WAIT: begin
                    r_dm_write <= 1'b1;
                    r_dm_wdata <= w_merged;
                    r_state    <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_dm_write   <= 1'b0;
                    r_dm_wdata   <= 16'd0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 16'd0;
                        r_resp_fault <= FLT_OK;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
